hazard_control_unit: RTL and testbench

//  Parametrised pipeline hazard controller for the 5-stage core; replaces the combinational load-use detector.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_stall_counter.sv | 42 ++++
 rtl/hazard_control_unit.sv | 173 +++++++++++++++++
 tb/tb_hazard_control_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_e     : controller state (idle / multi-cycle load-use stall)
//   REG_X0         : architectural zero register address (never a hazard source)
//   ID_EX_NOP_SEL  : ID/EX control mux select that loads NOP control
//   ID_EX_PASS_SEL : ID/EX control mux select that passes decoded control
// ----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [0:0] {
    HZ_IDLE  = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

  localparam logic [31:0] REG_X0         = 32'd0;
  localparam logic        ID_EX_NOP_SEL  = 1'b1;
  localparam logic        ID_EX_PASS_SEL = 1'b0;

endpackage

// File: rtl/hazard_stall_counter.sv
// ----------------------------------------------------------------------------
// hazard_stall_counter
// Down-counter tracking the remaining load-use stall cycles.
// Priority: reset/clear > load > decrement > hold. Decrement saturates at 0.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_clear     : force count to zero (stall aborted)
//   i_load      : load i_load_val
//   i_load_val  : reload value
//   i_dec       : decrement by one
//   o_done      : count equals one, i.e. this is the last stall cycle
// ----------------------------------------------------------------------------
module hazard_stall_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Remaining-stall counter update.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/hazard_control_unit.sv
// ----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline hazard controller sitting beside the ID stage of the 5-stage core.
// Handles multi-cycle load-use stalls, taken-branch flushes of IF/ID and ID/EX,
// and a whole-pipe freeze while data memory is busy.
// Priority (high to low): reset > dmem_busy > branch > load stall.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds stall_cycles/flush_count).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   id_valid, id_rs1, id_rs2   : ID instruction and its source registers
//   id_use_rs1, id_use_rs2     : ID instruction actually reads rs1/rs2
//   ex_mem_read, ex_rd         : EX instruction is a load, and its destination
//   ex_branch_taken            : EX resolved a taken branch/jump
//   dmem_busy                  : data memory not ready
//   pc_write, if_id_write      : front-end write enables
//   id_ex_bubble               : ID/EX loads NOP control
//   if_id_flush, id_ex_flush   : flush strobes
//   pipe_freeze                : back-end hold
//   stall_cycles, flush_count  : perf counters (HAZARD_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LOAD_STALLS = 1,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              pipe_freeze
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(LOAD_STALLS - 1);
  localparam bit               MULTI_STALL = (LOAD_STALLS > 1);

  hz_state_e r_state;
  hz_state_e w_state_nxt;
  logic      w_hit;
  logic      w_cnt_clear;
  logic      w_cnt_load;
  logic      w_cnt_dec;
  logic      w_cnt_done;

  // x0 is hard-wired zero, so a load targeting it cannot create a dependency.
  assign w_hit = id_valid && ex_mem_read && (ex_rd != REG_X0[REG_AW-1:0]) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));

  // Output decode and next-state selection in priority order.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = ID_EX_PASS_SEL;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    w_state_nxt  = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = ID_EX_NOP_SEL;
      w_state_nxt  = HZ_IDLE;
    end else if (dmem_busy) begin
      // EX is frozen and will re-present any taken branch once busy drops.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (ex_branch_taken) begin
      // Wrong-path instructions in IF/ID and ID/EX die; any stall is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_state_nxt = HZ_IDLE;
      w_cnt_clear = 1'b1;
    end else begin
      case (r_state)
        HZ_IDLE: begin
          if (w_hit) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = ID_EX_NOP_SEL;
            if (MULTI_STALL) begin
              w_state_nxt = HZ_STALL;
              w_cnt_load  = 1'b1;
            end else begin
              w_state_nxt = HZ_IDLE;
            end
          end else begin
            w_state_nxt = HZ_IDLE;
          end
        end
        HZ_STALL: begin
          // No re-detection here: the stall length is fixed at entry.
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = ID_EX_NOP_SEL;
          w_cnt_dec    = 1'b1;
          if (w_cnt_done) begin
            w_state_nxt = HZ_IDLE;
          end else begin
            w_state_nxt = HZ_STALL;
          end
        end
        default: begin
          w_state_nxt = HZ_IDLE;
          w_cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HZ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  hazard_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_cnt_clear),
    .i_load     (w_cnt_load),
    .i_load_val (RELOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_done     (w_cnt_done)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Free-running perf counters; wrap naturally at 2**32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      r_stall_cycles <= r_stall_cycles + {31'd0, id_ex_bubble};
      r_flush_count  <= r_flush_count + {31'd0, if_id_flush};
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       busy;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0;
  logic [4:0] id_rs2 = 5'd0;
  logic       id_use_rs1 = 1'b0;
  logic       id_use_rs2 = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rd = 5'd0;
  logic       ex_branch_taken = 1'b0;
  logic       dmem_busy = 1'b0;

  logic pc1, ifid1, bub1, iff1, ief1, frz1;
  logic pc3, ifid3, bub3, iff3, ief3, frz3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
  logic [31:0] exp_sc1 = 32'd0, exp_fc1 = 32'd0, exp_sc3 = 32'd0, exp_fc3 = 32'd0;
`endif

  int checks = 0;
  int errors = 0;
  int rem1 = 0;
  int rem3 = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_AW(5), .LOAD_STALLS(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc1), .if_id_write(ifid1), .id_ex_bubble(bub1), .if_id_flush(iff1),
    .id_ex_flush(ief1), .pipe_freeze(frz1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc1), .flush_count(fc1)
`endif
  );

  hazard_control_unit #(.REG_AW(5), .LOAD_STALLS(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc3), .if_id_write(ifid3), .id_ex_bubble(bub3), .if_id_flush(iff3),
    .id_ex_flush(ief3), .pipe_freeze(frz3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc3), .flush_count(fc3)
`endif
  );

  // Watchdog: the run is short; anything this long means a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t mk(input logic rst, input logic vld, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic mr, input logic [4:0] rd, input logic br,
                               input logic busy);
    stim_t s;
    s = {rst, vld, rs1, rs2, u1, u2, mr, rd, br, busy};
    return s;
  endfunction

  // Reference behaviour: returns {pc_write, if_id_write, bubble, if_id_flush, id_ex_flush, freeze}.
  // rem counts stall cycles still owed after the current one.
  function automatic logic [5:0] model(input stim_t s, input int ls, input int rem_in,
                                       output int rem_out);
    logic hit;
    hit = s.vld && s.mr && (s.rd != 5'd0) &&
          ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
    rem_out = rem_in;
    if (s.rst) begin
      rem_out = 0;
      return 6'b001000;
    end
    if (s.busy) return 6'b000001;
    if (s.br) begin
      rem_out = 0;
      return 6'b110110;
    end
    if (rem_in > 0) begin
      rem_out = rem_in - 1;
      return 6'b001000;
    end
    if (hit) begin
      rem_out = ls - 1;
      return 6'b001000;
    end
    return 6'b110000;
  endfunction

  // Drive one cycle of stimulus and push the expected outputs of both instances.
  task automatic step(input stim_t s);
    logic [5:0] e1, e3;
    int n1, n3;
    @(negedge clk);
    reset = s.rst; id_valid = s.vld; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; ex_mem_read = s.mr; ex_rd = s.rd;
    ex_branch_taken = s.br; dmem_busy = s.busy;
    e1 = model(s, 1, rem1, n1);
    e3 = model(s, 3, rem3, n3);
    sb.push_back({e1, e3});
    rem1 = n1;
    rem3 = n3;
    #2;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  // Advance the expected perf counters past the clock edge that ends this cycle.
  task automatic perf_advance(input logic [11:0] e, input logic rst);
    if (rst) begin
      exp_sc1 = 32'd0; exp_fc1 = 32'd0; exp_sc3 = 32'd0; exp_fc3 = 32'd0;
    end else begin
      exp_sc1 = exp_sc1 + {31'd0, e[9]};
      exp_fc1 = exp_fc1 + {31'd0, e[8]};
      exp_sc3 = exp_sc3 + {31'd0, e[3]};
      exp_fc3 = exp_fc3 + {31'd0, e[2]};
    end
  endtask
`endif

  task automatic test_reset();
    stim_t q[$];
    logic [11:0] e, o;
    q.push_back(mk(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1));
    q.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      o = {pc1, ifid1, bub1, iff1, ief1, frz1, pc3, ifid3, bub3, iff3, ief3, frz3};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b expected %b", i, o, e);
      end
`ifdef HAZARD_PERF_CNT_EN
      perf_advance(e, q[i].rst);
`endif
    end
  endtask

  task automatic test_load_stall();
    stim_t q[$];
    logic [11:0] e, o;
    int stalls3 = 0;
    // Hit held for three cycles (EX load blocks ID), then the load moves on.
    for (int k = 0; k < 3; k++)
      q.push_back(mk(1'b0, 1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0));
    // rs2 hit with use_rs2 set.
    q.push_back(mk(1'b0, 1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      o = {pc1, ifid1, bub1, iff1, ief1, frz1, pc3, ifid3, bub3, iff3, ief3, frz3};
      if (i < 5 && pc3 === 1'b0) stalls3++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_stall cyc%0d: got %b expected %b", i, o, e);
      end
`ifdef HAZARD_PERF_CNT_EN
      perf_advance(e, q[i].rst);
`endif
    end
    checks++;
    if (stalls3 !== 3) begin
      errors++;
      $display("FAIL load_stall_len3: got %0d stall cycles expected 3", stalls3);
    end
  endtask

  task automatic test_filter();
    stim_t q[$];
    logic [11:0] e, o;
    q.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd7, 5'd4, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd7, 5'd4, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      o = {pc1, ifid1, bub1, iff1, ief1, frz1, pc3, ifid3, bub3, iff3, ief3, frz3};
      checks++;
      if (o !== e || pc3 !== 1'b1) begin
        errors++;
        $display("FAIL filter cyc%0d: got %b expected %b", i, o, e);
      end
`ifdef HAZARD_PERF_CNT_EN
      perf_advance(e, q[i].rst);
`endif
    end
  endtask

  task automatic test_branch_flush();
    stim_t q[$];
    logic [11:0] e, o;
    q.push_back(mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      o = {pc1, ifid1, bub1, iff1, ief1, frz1, pc3, ifid3, bub3, iff3, ief3, frz3};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL branch_flush cyc%0d: got %b expected %b", i, o, e);
      end
`ifdef HAZARD_PERF_CNT_EN
      perf_advance(e, q[i].rst);
`endif
    end
  endtask

  task automatic test_dmem_freeze();
    stim_t q[$];
    logic [11:0] e, o;
    int stalls3 = 0;
    q.push_back(mk(1'b0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++)
      q.push_back(mk(1'b0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, k[0], 1'b1));
    q.push_back(mk(1'b0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      o = {pc1, ifid1, bub1, iff1, ief1, frz1, pc3, ifid3, bub3, iff3, ief3, frz3};
      if (bub3 === 1'b1) stalls3++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL dmem_freeze cyc%0d: got %b expected %b", i, o, e);
      end
`ifdef HAZARD_PERF_CNT_EN
      perf_advance(e, q[i].rst);
`endif
    end
    checks++;
    if (stalls3 !== 3) begin
      errors++;
      $display("FAIL freeze_stall_len3: got %0d unfrozen stall cycles expected 3", stalls3);
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t q[$];
    logic [11:0] e, o;
    q.push_back(mk(1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0));
    q.push_back(mk(1'b1, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0));
    // A fresh hit right after reset must restart a full-length stall.
    for (int k = 0; k < 4; k++)
      q.push_back(mk(1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, k < 1, 5'd4, 1'b0, 1'b0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      o = {pc1, ifid1, bub1, iff1, ief1, frz1, pc3, ifid3, bub3, iff3, ief3, frz3};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_stall cyc%0d: got %b expected %b", i, o, e);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (i == 3) begin
        @(posedge clk);
        #1;
        checks++;
        if (sc1 !== 32'd0 || fc1 !== 32'd0 || sc3 !== 32'd0 || fc3 !== 32'd0) begin
          errors++;
          $display("FAIL perf_cleared: got %0d %0d %0d %0d expected 0", sc1, fc1, sc3, fc3);
        end
      end
      perf_advance(e, q[i].rst);
`endif
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    logic [11:0] e, o;
    q.push_back(mk(1'b0, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1));
    q.push_back(mk(1'b0, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      o = {pc1, ifid1, bub1, iff1, ief1, frz1, pc3, ifid3, bub3, iff3, ief3, frz3};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", i, o, e);
      end
`ifdef HAZARD_PERF_CNT_EN
      perf_advance(e, q[i].rst);
`endif
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    @(posedge clk);
    #1;
    checks++;
    if (sc1 !== exp_sc1 || fc1 !== exp_fc1 || sc3 !== exp_sc3 || fc3 !== exp_fc3) begin
      errors++;
      $display("FAIL perf_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
               sc1, fc1, sc3, fc3, exp_sc1, exp_fc1, exp_sc3, exp_fc3);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_stall();
    test_filter();
    test_branch_flush();
    test_dmem_freeze();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
